// File: rtl/fnd_reg_scanner.sv
`default_nettype none
// ============================================================================
// fnd_reg_scanner : shows one register channel on a 4-digit 7-segment display
//                   (digit3 = channel, digits 2..0 = value), manual or auto scan
// Revision: 1.0
// ============================================================================
module fnd_reg_scanner #(
  parameter int NUM_CH      = 7,
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DWELL       = 100000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        sw,
  input  logic                     auto_en,
  input  logic [NUM_CH*DATA_W-1:0] regs,
  output logic [7:0]               fndFont,
  output logic [3:0]               fndCom,
  output logic [3:0]               ch_idx,
  output logic                     ch_valid
);

  localparam int c_ref_w   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_dwell_w = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [c_ref_w-1:0]   c_ref_last   = c_ref_w'(REFRESH_DIV - 1);
  localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);
  localparam logic [3:0]           c_ch_last    = 4'(NUM_CH - 1);

  function automatic logic [7:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0:    hex_font = 8'hC0;
      4'h1:    hex_font = 8'hF9;
      4'h2:    hex_font = 8'hA4;
      4'h3:    hex_font = 8'hB0;
      4'h4:    hex_font = 8'h99;
      4'h5:    hex_font = 8'h92;
      4'h6:    hex_font = 8'h82;
      4'h7:    hex_font = 8'hF8;
      4'h8:    hex_font = 8'h80;
      4'h9:    hex_font = 8'h90;
      4'hA:    hex_font = 8'h88;
      4'hB:    hex_font = 8'h83;
      4'hC:    hex_font = 8'hC6;
      4'hD:    hex_font = 8'hA1;
      4'hE:    hex_font = 8'h86;
      default: hex_font = 8'h8E;
    endcase
  endfunction

  logic [c_ref_w-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [1:0]           digit_sel_q, digit_sel_d;
  logic [c_dwell_w-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [3:0]           ch_idx_q, ch_idx_d;
  logic                 ch_valid_q, ch_valid_d;
  logic                 auto_prev_q, auto_prev_d;
  logic                 chg_q, chg_d;
  logic [DATA_W-1:0]    snap_q, snap_d;
  logic [3:0]           fnd_com_q, fnd_com_d;
  logic [7:0]           fnd_font_q, fnd_font_d;

  logic                 ref_wrap;
  logic [4:0]           sw_ones;
  logic [3:0]           sw_idx;
  logic                 sw_onehot;
  logic [DATA_W-1:0]    reg_sel;
  logic [11:0]          snap_ext;
  logic [3:0]           nibble;

  always_comb begin : p_sw_decode
    sw_ones = '0;
    sw_idx  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sw[k]) begin
        sw_ones = sw_ones + 5'd1;
        sw_idx  = 4'(k);
      end
    end
    sw_onehot = (sw_ones == 5'd1);
  end

  always_comb begin : p_reg_mux
    reg_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx_q == 4'(k)) begin
        reg_sel = regs[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : p_next
    ref_wrap      = (refresh_cnt_q == c_ref_last);
    refresh_cnt_d = ref_wrap ? '0 : refresh_cnt_q + c_ref_w'(1);
    digit_sel_d   = ref_wrap ? digit_sel_q + 2'd1 : digit_sel_q;

    auto_prev_d = auto_en;
    dwell_cnt_d = '0;
    ch_idx_d    = ch_idx_q;
    ch_valid_d  = ch_valid_q;

    if (auto_en && !auto_prev_q) begin
      // entering auto mode always restarts the scan from channel 0
      ch_idx_d   = '0;
      ch_valid_d = 1'b1;
    end else if (auto_en) begin
      ch_valid_d = 1'b1;
      if (dwell_cnt_q == c_dwell_last) begin
        ch_idx_d = (ch_idx_q >= c_ch_last) ? 4'd0 : ch_idx_q + 4'd1;
      end else begin
        dwell_cnt_d = dwell_cnt_q + c_dwell_w'(1);
      end
    end else if (sw_onehot) begin
      ch_idx_d   = sw_idx;
      ch_valid_d = 1'b1;
    end else begin
      ch_valid_d = 1'b0;
    end

    chg_d = (ch_idx_d != ch_idx_q) || (ch_valid_d != ch_valid_q);

    // value is frozen for a whole frame so digits never mix old and new data
    snap_d = (chg_q || (ref_wrap && (digit_sel_q == 2'd3))) ? reg_sel : snap_q;

    snap_ext               = '0;
    snap_ext[DATA_W-1:0]   = snap_q;
    case (digit_sel_q)
      2'd0:    nibble = snap_ext[3:0];
      2'd1:    nibble = snap_ext[7:4];
      2'd2:    nibble = snap_ext[11:8];
      default: nibble = ch_idx_q;
    endcase

    fnd_com_d  = ~(4'b0001 << digit_sel_q);
    fnd_font_d = ch_valid_q ? hex_font(nibble) : 8'hFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= '0;
      dwell_cnt_q   <= '0;
      ch_idx_q      <= '0;
      ch_valid_q    <= 1'b0;
      auto_prev_q   <= 1'b0;
      chg_q         <= 1'b0;
      snap_q        <= '0;
      fnd_com_q     <= 4'b1111;
      fnd_font_q    <= 8'hFF;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_sel_q   <= digit_sel_d;
      dwell_cnt_q   <= dwell_cnt_d;
      ch_idx_q      <= ch_idx_d;
      ch_valid_q    <= ch_valid_d;
      auto_prev_q   <= auto_prev_d;
      chg_q         <= chg_d;
      snap_q        <= snap_d;
      fnd_com_q     <= fnd_com_d;
      fnd_font_q    <= fnd_font_d;
    end
  end

  assign fndFont  = fnd_font_q;
  assign fndCom   = fnd_com_q;
  assign ch_idx   = ch_idx_q;
  assign ch_valid = ch_valid_q;

endmodule
`default_nettype wire
